alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Iterative shift-add multiplier sequencer that borrows the shared ALU adder to compute the low D_WIDTH bits of an unsigned product (RISC-V MUL semantics: low word identical for signed and unsigned). It sits beside the ALU in the datapath. While it owns the adder, it drives the ALU operand and control inputs and raises `busy`, which selects its operands over the main datapath's. It accepts one request at a time via a start/ready handshake and returns the product with a one-cycle `done` pulse.

## Interface
- D_WIDTH, 32, operand/result width
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when `ready`=1
- mcand  input  D_WIDTH  multiplicand, captured with `start`
- mplier  input  D_WIDTH  multiplier, captured with `start`
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN; top-level ALU operand mux select
- done  output  1  one-cycle pulse, product valid
- product  output  D_WIDTH  registered result, held until next accepted start
- alu_op1  output  D_WIDTH  to ALU aluop1 (accumulator)
- alu_op2  output  D_WIDTH  to ALU regop2 (shifted multiplicand)
- alusrc  output  1  constant 0 (register operand)
- aluctrl  output  3  constant ALU_ADD (3'b000)
- alu_result  input  D_WIDTH  ALU aluout

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `ready`=1. When `start`=1:
  - If mcand==0 or mplier==0: acc<=0, go to DONE.
  - Otherwise: acc<=0, mc<=mcand, mp<=mplier, go to RUN.
- RUN, each cycle:
  - alu_op1=acc, alu_op2=mc.
  - If mp[0]=1: acc<=alu_result.
  - mc<=mc<<1 (bits shifted out are discarded); mp<=mp>>1.
  - If (mp>>1)==0, go to DONE; otherwise stay in RUN.
- DONE: `done`=1 for exactly one cycle; product<=acc is loaded on entry. Go to IDLE unconditionally.
- `start` in RUN or DONE is ignored; the requester holds it until it sees `ready`.
- Arithmetic is modulo 2^D_WIDTH. No carry-out or overflow flag. The ALU `eq` output is unused.
- Outside RUN, alu_op1 and alu_op2 are 0.

## Timing
- Reset (next edge with rst=1):
  - state=IDLE, acc/mc/mp/product=0.
  - ready=1, busy=0, done=0, alu_op1=alu_op2=0.
- Reset during RUN or DONE aborts the operation with no `done` pulse. product reads 0.
- Latency from start accepted at edge 0:
  - N = index of highest set bit of mplier + 1, so 1..D_WIDTH.
  - RUN occupies cycles 1..N. `done` and the valid product appear at cycle N+1. `ready` returns at cycle N+2.
- Zero operand: `done` at cycle 1, product=0, no RUN cycles, busy never asserted.
- The ALU is purely combinational: alu_result is consumed in the same RUN cycle, with no pipeline stage.
- Back-to-back requests: minimum spacing is N+2 cycles.

## Structure
- Shared package `alu_pkg`:
  - ALU control constants, including ALU_ADD=3'b000 and the other aluctrl codes.
  - State typedef for this block: enum logic [1:0] {IDLE, RUN, DONE}.
- No sub-module. The ALU stays instantiated at the top level. The top-level mux uses `busy` to choose between sequencer operands and decode operands, and forces the ALU alusrc/aluctrl from this block while `busy`=1.
- One FSM, three D_WIDTH working registers (acc, mc, mp), and one product register.

## Test plan
- Reset: assert rst for 2 cycles → ready=1, busy=0, done=0, product=0, alu_op1=alu_op2=0.
- mcand=7, mplier=5:
  - busy high for exactly cycles 1–3.
  - done at cycle 4 with product=35.
  - ready again at cycle 5.
- mcand=0xFFFFFFFF, mplier=0xFFFFFFFF → 32 RUN cycles, done at cycle 33, product=0x00000001 (wrap).
- mcand=123, mplier=0 → done at cycle 1, product=0, busy never high. Repeat with mcand=0, mplier=9: same response.
- Busy-time stimuli:
  - Pulse start with mcand=3, mplier=3 during RUN of a 6×6 request → ignored; done shows product=36.
  - Assert rst at the second RUN cycle of 6×6 → no done pulse, IDLE next cycle, product=0.
- Random check: 1000 random operand pairs with ALU model attached → product == (mcand*mplier) mod 2^32, done latency == N+1 every time.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ALU datapath and the iterative
// multiplier sequencer.
//   - aluctrl codes (ALU_ADD is the only one the sequencer drives)
//   - mul_state_e: the three-state control FSM of alu_mul_sequencer
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-add multiplier that borrows the shared ALU adder
// to produce the low D_WIDTH bits of mcand*mplier.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   start, ready       request handshake: a request is taken on a rising edge
//                      where start=1 and ready=1 (ready is high only in IDLE);
//                      start in any other state is ignored
//   mcand, mplier      operands, captured with the accepted start
//   busy               high while the adder is owned (RUN); ALU operand mux select
//   done, product      one-cycle done pulse; product held until overwritten
//   alu_op1, alu_op2   accumulator / shifted multiplicand to the ALU (0 outside RUN)
//   alusrc, aluctrl    constant register-operand / ADD control for the ALU
//   alu_result         combinational ALU sum, consumed in the same cycle
//   fsm_state          current FSM state, for observation
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [D_WIDTH-1:0] mcand,
    input  logic [D_WIDTH-1:0] mplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [D_WIDTH-1:0] product,
    output logic [D_WIDTH-1:0] alu_op1,
    output logic [D_WIDTH-1:0] alu_op2,
    output logic               alusrc,
    output logic [2:0]         aluctrl,
    input  logic [D_WIDTH-1:0] alu_result,
    output logic [1:0]         fsm_state
);

    mul_state_e         state;
    logic [D_WIDTH-1:0] acc;
    logic [D_WIDTH-1:0] mc;
    logic [D_WIDTH-1:0] mp;

    // Accumulator value after this RUN cycle: add only when the current
    // multiplier bit is set.
    logic [D_WIDTH-1:0] acc_next;
    assign acc_next = mp[0] ? alu_result : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            mc      <= '0;
            mp      <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        if (mcand == '0 || mplier == '0) begin
                            // Trivial product: skip RUN, adder never borrowed.
                            product <= '0;
                            state   <= DONE;
                        end else begin
                            mc    <= mcand;
                            mp    <= mplier;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    mc  <= mc << 1;
                    mp  <= mp >> 1;
                    // Stop once no set multiplier bits remain; the product
                    // is loaded together with the move to DONE so it is
                    // valid in the same cycle as the done pulse.
                    if ((mp >> 1) == '0) begin
                        product <= acc_next;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign alu_op1   = busy ? acc : '0;
    assign alu_op2   = busy ? mc  : '0;
    assign alusrc    = 1'b0;
    assign aluctrl   = ALU_ADD;
    assign fsm_state = state;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Testbench for alu_mul_sequencer with a combinational ALU model attached.
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic [W-1:0] mcand = '0;
    logic [W-1:0] mplier = '0;
    logic         ready, busy, done;
    logic [W-1:0] product, alu_op1, alu_op2, alu_result;
    logic         alusrc;
    logic [2:0]   aluctrl;
    logic [1:0]   fsm_state;

    // ALU model: add for register operand + ADD control, else zero
    assign alu_result = (!alusrc && aluctrl == ALU_ADD) ? (alu_op1 + alu_op2) : '0;

    alu_mul_sequencer #(.D_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
        .ready(ready), .busy(busy), .done(done), .product(product),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alusrc(alusrc), .aluctrl(aluctrl),
        .alu_result(alu_result), .fsm_state(fsm_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == '0 || b == '0) return 1;
        for (int i = W - 1; i >= 0; i--) begin
            if (b[i]) return i + 2;
        end
        return 1;
    endfunction

    // ---------------- driver ----------------
    // Drives one request and follows it to the done pulse, checking per-cycle
    // operand outputs, latency, busy length and the return of ready.
    // With pulse_mid set, a stray 3x3 start is pulsed during RUN.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_p, input int exp_lat,
                           input bit pulse_mid);
        int k;
        int busy_n;
        bit seen;
        logic [W-1:0] shifted;
        logic [W-1:0] got;
        @(negedge clk);
        chk("ready_before_start", ready, 1);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        exp_q.push_back(exp_p);
        @(negedge clk);
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        k = 1;
        busy_n = 0;
        seen = 1'b0;
        while (k <= 40 && !seen) begin
            if (pulse_mid && k == 2) begin
                start  = 1'b1;
                mcand  = 3;
                mplier = 3;
            end else begin
                start  = 1'b0;
            end
            if (busy) begin
                busy_n++;
                shifted = a << (k - 1);
                chk("alu_op2_run", alu_op2, shifted);
                chk("aluctrl_run", {alusrc, aluctrl}, {1'b0, ALU_ADD});
            end else begin
                chk("alu_ops_idle", {alu_op1, alu_op2}, 64'd0);
            end
            if (done) begin
                seen = 1'b1;
                chk("done_latency", k, exp_lat);
                if (exp_q.size() == 0) begin
                    chk("exp_q_nonempty", 0, 1);
                end else begin
                    got = exp_q.pop_front();
                    chk("product", product, got);
                end
            end else begin
                k++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no done within 40 cycles for %0h*%0h", a, b);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        chk("busy_cycles", busy_n, exp_lat - 1);
        @(negedge clk);
        chk("ready_after_done", ready, 1);
        chk("done_one_cycle", done, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
        int           lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{a: 32'd7,          b: 32'd5,          p: 32'd35,         lat: 4};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  p: 32'h0000_0001,  lat: 33};
        vecs[2] = '{a: 32'd123,        b: 32'd0,          p: 32'd0,          lat: 1};
        vecs[3] = '{a: 32'd0,          b: 32'd9,          p: 32'd0,          lat: 1};
        vecs[4] = '{a: 32'd6,          b: 32'd6,          p: 32'd36,         lat: 4};
        vecs[5] = '{a: 32'd1,          b: 32'd1,          p: 32'd1,          lat: 2};
        vecs[6] = '{a: 32'd1,          b: 32'h8000_0000,  p: 32'h8000_0000,  lat: 33};
        vecs[7] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  p: 32'd0,          lat: 18};

        // Reset for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_product", product, 0);
        chk("reset_alu_ops", {alu_op1, alu_op2}, 64'd0);
        chk("reset_state", fsm_state, IDLE);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat, 1'b0);
        end

        // Stray start during RUN must be ignored
        run_mul(32'd6, 32'd6, 32'd36, 4, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("no_extra_done", done, 0);
            chk("idle_after_ignored", ready, 1);
        end

        // Reset in the second RUN cycle aborts with no done
        @(negedge clk);
        start  = 1'b1;
        mcand  = 32'd6;
        mplier = 32'd6;
        @(negedge clk);
        start  = 1'b0;
        chk("abort_run_c1", busy, 1);
        @(negedge clk);
        chk("abort_run_c2", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_idle", ready, 1);
        chk("abort_no_done", done, 0);
        chk("abort_product", product, 0);
        @(negedge clk);
        chk("abort_no_done_later", done, 0);
        chk("abort_still_idle", fsm_state, IDLE);

        // Random operand pairs
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [W-1:0] rp;
            ra = $urandom() >> $urandom_range(0, 31);
            rb = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 49) == 0) rb = '0;
            rp = ra * rb;
            run_mul(ra, rb, rp, lat_of(ra, rb), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
